inter_layer_block_scheduler_core: RTL and testbench



---
 rtl/inter_layer_block_scheduler_core_pkg.sv | 46 ++++
 rtl/ilbs_cost_compare.sv | 27 ++
 rtl/inter_layer_block_scheduler_core.sv | 150 +++++++++++++++
 tb/tb_inter_layer_block_scheduler_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inter_layer_block_scheduler_core_pkg.sv
// Shared types for the inter-layer block scheduler: block-type encodings,
// FSM states, the latched request payload and the layer-address helpers.
package inter_layer_block_scheduler_core_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [1:0] {
    FORWARD_FORWARD   = 2'd0,
    FORWARD_BACKWARD  = 2'd1,
    BACKWARD_FORWARD  = 2'd2,
    BACKWARD_BACKWARD = 2'd3
  } block_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ0 = 3'd1,
    ST_READ1 = 3'd2,
    ST_EVAL  = 3'd3,
    ST_FUSE  = 3'd4
  } state_e;

  typedef struct packed {
    block_type_e       btype;
    logic [DATA_W-1:0] start0;
    logic [DATA_W-1:0] start1;
    logic [DATA_W-1:0] len0;
    logic [DATA_W-1:0] len1;
    logic [DATA_W-1:0] npu_cap;
    logic [DATA_W-1:0] cim_cap;
    logic [DATA_W-1:0] threshold;
  } sched_req_t;

  // bit1 of the block type is block0's direction, bit0 is block1's
  function automatic logic is_backward(input block_type_e bt, input logic blk);
    return blk ? bt[0] : bt[1];
  endfunction

  function automatic logic [DATA_W-1:0] layer_addr(input logic              bwd,
                                                   input logic [DATA_W-1:0] start,
                                                   input logic [DATA_W-1:0] len,
                                                   input logic [DATA_W-1:0] k);
    return bwd ? (start + len - DATA_W'(1) - k) : (start + k);
  endfunction

endpackage

// File: rtl/ilbs_cost_compare.sv
// Capability-weighted cost comparison: flags an excessive bubble and picks
// the cheaper block (0 = block0, 1 = block1).
module ilbs_cost_compare
  import inter_layer_block_scheduler_core_pkg::*;
(
  input  logic [DATA_W-1:0] acc0,
  input  logic [DATA_W-1:0] acc1,
  input  logic [DATA_W-1:0] npu_cap,
  input  logic [DATA_W-1:0] cim_cap,
  input  logic [DATA_W-1:0] threshold,
  output logic              over_c,
  output logic              side_c
);

  logic [PROD_W-1:0] t0;
  logic [PROD_W-1:0] t1;
  logic [PROD_W-1:0] diff;

  always_comb begin
    t0     = PROD_W'(acc0) * PROD_W'(cim_cap);
    t1     = PROD_W'(acc1) * PROD_W'(npu_cap);
    diff   = (t0 > t1) ? (t0 - t1) : (t1 - t0);
    over_c = diff > PROD_W'(threshold);
    side_c = !(t0 < t1);
  end

endmodule

// File: rtl/inter_layer_block_scheduler_core.sv
// Pairs two layer blocks, reads their first-layer costs and fuses further
// layers into the cheaper side until the weighted bubble fits the threshold.
module inter_layer_block_scheduler_core
  import inter_layer_block_scheduler_core_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] npu_capability_i,
  input  logic [DATA_W-1:0] in_pipeline_cim_capability_i,
  input  logic [DATA_W-1:0] bubble_threshold_i,
  output logic [DATA_W-1:0] config_mem_addr_o,
  output logic              config_mem_read_valid_o,
  input  logic [DATA_W-1:0] config_mem_read_data_i,
  input  logic              config_mem_read_ready_i,
  input  logic [1:0]        block_type_i,
  input  logic [DATA_W-1:0] block0_start_i,
  input  logic [DATA_W-1:0] block1_start_i,
  input  logic [DATA_W-1:0] block0_length_i,
  input  logic [DATA_W-1:0] block1_length_i,
  input  logic              schedule_valid_i,
  output logic              schedule_ready_o
);

  state_e            state;
  state_e            state_nxt;
  sched_req_t        req;
  logic [DATA_W-1:0] acc0;
  logic [DATA_W-1:0] acc1;
  logic [DATA_W-1:0] k0;
  logic [DATA_W-1:0] k1;
  logic              side;
  logic              accept_c;
  logic              zero_len_c;
  logic              over_c;
  logic              side_c;
  logic              exhausted_c;
  logic [DATA_W-1:0] addr0_c;
  logic [DATA_W-1:0] addr1_c;

  ilbs_cost_compare u_cost_compare (
    .acc0      (acc0),
    .acc1      (acc1),
    .npu_cap   (req.npu_cap),
    .cim_cap   (req.cim_cap),
    .threshold (req.threshold),
    .over_c    (over_c),
    .side_c    (side_c)
  );

  assign accept_c    = (state == ST_IDLE) && schedule_valid_i;
  assign zero_len_c  = (block0_length_i == '0) || (block1_length_i == '0);
  assign exhausted_c = side_c ? (k1 == req.len1) : (k0 == req.len0);
  assign addr0_c     = layer_addr(is_backward(req.btype, 1'b0), req.start0, req.len0, k0);
  assign addr1_c     = layer_addr(is_backward(req.btype, 1'b1), req.start1, req.len1, k1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state plus read-port and ready decode
  always_comb begin
    state_nxt               = state;
    config_mem_read_valid_o = 1'b0;
    config_mem_addr_o       = '0;
    schedule_ready_o        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        schedule_ready_o = 1'b1;
        if (accept_c && !zero_len_c) state_nxt = ST_READ0;
      end
      ST_READ0: begin
        config_mem_read_valid_o = 1'b1;
        config_mem_addr_o       = addr0_c;
        if (config_mem_read_ready_i) state_nxt = ST_READ1;
      end
      ST_READ1: begin
        config_mem_read_valid_o = 1'b1;
        config_mem_addr_o       = addr1_c;
        if (config_mem_read_ready_i) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        state_nxt = (!over_c || exhausted_c) ? ST_IDLE : ST_FUSE;
      end
      ST_FUSE: begin
        config_mem_read_valid_o = 1'b1;
        config_mem_addr_o       = side ? addr1_c : addr0_c;
        if (config_mem_read_ready_i) state_nxt = ST_EVAL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, accumulators and consumed-layer counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req  <= '0;
      acc0 <= '0;
      acc1 <= '0;
      k0   <= '0;
      k1   <= '0;
      side <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            req.btype     <= block_type_e'(block_type_i);
            req.start0    <= block0_start_i;
            req.start1    <= block1_start_i;
            req.len0      <= block0_length_i;
            req.len1      <= block1_length_i;
            req.npu_cap   <= npu_capability_i;
            req.cim_cap   <= in_pipeline_cim_capability_i;
            req.threshold <= bubble_threshold_i;
            acc0          <= '0;
            acc1          <= '0;
            k0            <= '0;
            k1            <= '0;
          end
        end
        ST_READ0: begin
          if (config_mem_read_ready_i) begin
            acc0 <= config_mem_read_data_i;
            k0   <= DATA_W'(1);
          end
        end
        ST_READ1: begin
          if (config_mem_read_ready_i) begin
            acc1 <= config_mem_read_data_i;
            k1   <= DATA_W'(1);
          end
        end
        ST_EVAL: side <= side_c;
        ST_FUSE: begin
          if (config_mem_read_ready_i) begin
            if (side) begin
              acc1 <= acc1 + config_mem_read_data_i;
              k1   <= k1 + DATA_W'(1);
            end else begin
              acc0 <= acc0 + config_mem_read_data_i;
              k0   <= k0 + DATA_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inter_layer_block_scheduler_core.sv
// Self-checking bench: directed block-type scenarios, stall/reset handling and
// randomized requests against a layer-fusion reference model.
module tb_inter_layer_block_scheduler_core;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] npu_capability_i;
  logic [31:0] in_pipeline_cim_capability_i;
  logic [31:0] bubble_threshold_i;
  logic [31:0] config_mem_addr_o;
  logic        config_mem_read_valid_o;
  logic [31:0] config_mem_read_data_i;
  logic        config_mem_read_ready_i;
  logic [1:0]  block_type_i;
  logic [31:0] block0_start_i;
  logic [31:0] block1_start_i;
  logic [31:0] block0_length_i;
  logic [31:0] block1_length_i;
  logic        schedule_valid_i;
  logic        schedule_ready_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];
  logic [31:0] exp_addr [$];

  always #5 clk_i = ~clk_i;

  inter_layer_block_scheduler_core dut (
    .clk_i                        (clk_i),
    .rst_ni                       (rst_ni),
    .npu_capability_i             (npu_capability_i),
    .in_pipeline_cim_capability_i (in_pipeline_cim_capability_i),
    .bubble_threshold_i           (bubble_threshold_i),
    .config_mem_addr_o            (config_mem_addr_o),
    .config_mem_read_valid_o      (config_mem_read_valid_o),
    .config_mem_read_data_i       (config_mem_read_data_i),
    .config_mem_read_ready_i      (config_mem_read_ready_i),
    .block_type_i                 (block_type_i),
    .block0_start_i               (block0_start_i),
    .block1_start_i               (block1_start_i),
    .block0_length_i              (block0_length_i),
    .block1_length_i              (block1_length_i),
    .schedule_valid_i             (schedule_valid_i),
    .schedule_ready_o             (schedule_ready_o)
  );

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input bit bwd, input logic [31:0] st,
                                          input logic [31:0] ln, input logic [31:0] k);
    return bwd ? st + ln - 32'd1 - k : st + k;
  endfunction

  // Reference: expected read addresses for one request, and the fuse count
  task automatic model(input logic [1:0] bt, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] npu,
                       input logic [31:0] cim, input logic [31:0] thr, output int nfuse);
    logic [31:0] st [2];
    logic [31:0] ln [2];
    logic [31:0] cost [2];
    logic [31:0] used [2];
    bit          bwd [2];
    logic [63:0] w0, w1, gap;
    logic [31:0] a;
    int          s;
    exp_addr.delete();
    nfuse = 0;
    if (l0 == 0 || l1 == 0) return;
    st[0] = s0; st[1] = s1; ln[0] = l0; ln[1] = l1;
    bwd[0] = bt[1]; bwd[1] = bt[0];
    for (int b = 0; b < 2; b++) begin
      a = addr_of(bwd[b], st[b], ln[b], 32'd0);
      exp_addr.push_back(a);
      cost[b] = mem[a[7:0]];
      used[b] = 32'd1;
    end
    forever begin
      w0  = 64'(cost[0]) * 64'(cim);
      w1  = 64'(cost[1]) * 64'(npu);
      gap = (w0 > w1) ? w0 - w1 : w1 - w0;
      if (gap <= 64'(thr)) break;
      s = (w0 < w1) ? 0 : 1;
      if (used[s] == ln[s]) break;
      a = addr_of(bwd[s], st[s], ln[s], used[s]);
      exp_addr.push_back(a);
      cost[s] = cost[s] + mem[a[7:0]];
      used[s] = used[s] + 32'd1;
      nfuse++;
    end
  endtask

  // Issue one request (called at a negedge with the core idle) and serve its reads
  task automatic run_txn(input logic [1:0] bt, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] npu,
                         input logic [31:0] cim, input logic [31:0] thr, input int stall_pct,
                         input string tag);
    int nfuse, busy, stalls, rd, exp_busy;
    model(bt, s0, s1, l0, l1, npu, cim, thr, nfuse);
    check(64'(schedule_ready_o), 64'd1, {tag, "_ready_at_start"});
    block_type_i = bt; block0_start_i = s0; block1_start_i = s1;
    block0_length_i = l0; block1_length_i = l1;
    npu_capability_i = npu; in_pipeline_cim_capability_i = cim; bubble_threshold_i = thr;
    schedule_valid_i = 1'b1;
    @(negedge clk_i);
    schedule_valid_i = 1'b0;
    block0_start_i = $urandom; block1_start_i = $urandom; block_type_i = 2'($urandom);
    busy = 0; stalls = 0; rd = 0;
    while (!schedule_ready_o && busy < 400) begin
      busy++;
      if (config_mem_read_valid_o) begin
        if (rd < exp_addr.size())
          check(64'(config_mem_addr_o), 64'(exp_addr[rd]), {tag, "_addr"});
        else
          check(64'(rd), 64'(exp_addr.size()), {tag, "_extra_read"});
        if ($urandom_range(99) < stall_pct) begin
          config_mem_read_ready_i = 1'b0;
          stalls++;
        end else begin
          config_mem_read_ready_i = 1'b1;
          config_mem_read_data_i  = mem[config_mem_addr_o[7:0]];
          rd++;
        end
      end else begin
        check(64'(config_mem_addr_o), 64'd0, {tag, "_addr_idle"});
        config_mem_read_ready_i = 1'($urandom_range(1));
        config_mem_read_data_i  = $urandom;
      end
      @(negedge clk_i);
    end
    config_mem_read_ready_i = 1'b0;
    exp_busy = (exp_addr.size() == 0) ? 0 : 3 + 2 * nfuse + stalls;
    check(64'(schedule_ready_o), 64'd1, {tag, "_done"});
    check(64'(rd), 64'(exp_addr.size()), {tag, "_reads"});
    check(64'(busy), 64'(exp_busy), {tag, "_cycles"});
  endtask

  initial begin
    int rs0, rs1;
    rst_ni = 1'b0;
    schedule_valid_i = 1'b0; config_mem_read_ready_i = 1'b0; config_mem_read_data_i = '0;
    block_type_i = '0; block0_start_i = '0; block1_start_i = '0;
    block0_length_i = '0; block1_length_i = '0;
    npu_capability_i = 32'd3; in_pipeline_cim_capability_i = 32'd1; bubble_threshold_i = 32'd300;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset values
    repeat (2) @(negedge clk_i);
    check(64'(config_mem_read_valid_o), 64'd0, "rst_valid");
    check(64'(config_mem_addr_o), 64'd0, "rst_addr");
    check(64'(schedule_ready_o), 64'd1, "rst_ready");
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check(64'(config_mem_read_valid_o), 64'd0, "post_rst_valid");
    check(64'(config_mem_addr_o), 64'd0, "post_rst_addr");
    check(64'(schedule_ready_o), 64'd1, "post_rst_ready");

    // FORWARD_FORWARD: two fuses into block0
    mem[4] = 32'd222; mem[0] = 32'd333; mem[5] = 32'd400; mem[6] = 32'd100;
    run_txn(2'd0, 32'd4, 32'd0, 32'd4, 32'd4, 32'd3, 32'd1, 32'd300, 0, "ff");
    check(64'(exp_addr.size()), 64'd4, "ff_model_reads");

    // BACKWARD_BACKWARD: balanced immediately
    mem[7] = 32'd900; mem[3] = 32'd300;
    run_txn(2'd3, 32'd4, 32'd0, 32'd4, 32'd4, 32'd3, 32'd1, 32'd300, 0, "bb");

    // FORWARD_BACKWARD: block0 exhausted after three fuses
    mem[0] = 32'd111; mem[7] = 32'd777; mem[1] = 32'd1; mem[2] = 32'd1; mem[3] = 32'd1;
    run_txn(2'd1, 32'd0, 32'd4, 32'd4, 32'd4, 32'd3, 32'd1, 32'd300, 0, "fb");

    // BACKWARD_FORWARD: one fuse into block1
    mem[3] = 32'd999; mem[4] = 32'd10; mem[5] = 32'd400;
    run_txn(2'd2, 32'd0, 32'd4, 32'd4, 32'd4, 32'd3, 32'd1, 32'd300, 0, "bf");

    // Zero-length request issues no reads
    run_txn(2'd0, 32'd8, 32'd9, 32'd0, 32'd3, 32'd3, 32'd1, 32'd300, 0, "zero_len");

    // Randomized requests with random read stalls
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'($urandom_range(255));
      rs0 = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(200));
      rs1 = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(200));
      run_txn(2'($urandom), 32'(rs0), 32'(rs1), 32'($urandom_range(5)), 32'($urandom_range(5)),
              32'($urandom_range(4, 1)), 32'($urandom_range(4, 1)), 32'($urandom_range(600)),
              30, "rand");
    end

    // Stall in FUSE, then reset mid-read
    mem[4] = 32'd222; mem[0] = 32'd333; mem[5] = 32'd400; mem[6] = 32'd100;
    block_type_i = 2'd0; block0_start_i = 32'd4; block1_start_i = 32'd0;
    block0_length_i = 32'd4; block1_length_i = 32'd4;
    npu_capability_i = 32'd3; in_pipeline_cim_capability_i = 32'd1; bubble_threshold_i = 32'd300;
    schedule_valid_i = 1'b1;
    @(negedge clk_i);
    schedule_valid_i = 1'b0;
    config_mem_read_ready_i = 1'b1; config_mem_read_data_i = 32'd222;
    @(negedge clk_i);
    config_mem_read_data_i = 32'd333;
    @(negedge clk_i);
    config_mem_read_ready_i = 1'b0;
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) begin
      block0_start_i = $urandom; block_type_i = 2'd3; block0_length_i = 32'd1;
      check(64'(config_mem_read_valid_o), 64'd1, "stall_valid");
      check(64'(config_mem_addr_o), 64'd5, "stall_addr");
      @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    check(64'(config_mem_read_valid_o), 64'd0, "midrst_valid");
    check(64'(config_mem_addr_o), 64'd0, "midrst_addr");
    check(64'(schedule_ready_o), 64'd1, "midrst_ready");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Recovery after reset
    mem[3] = 32'd999; mem[4] = 32'd10; mem[5] = 32'd400;
    run_txn(2'd2, 32'd0, 32'd4, 32'd4, 32'd4, 32'd3, 32'd1, 32'd300, 20, "bf_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
